// File: rtl/rf_multiport_if.sv
// rtl/rf_multiport_if.sv - write port and two read ports of the multiport register file
interface rf_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              ren_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;
  logic              ren_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rvalid_b;

  modport master (
    output wen, waddr, wdata, ren_a, raddr_a, ren_b, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  wen, waddr, wdata, ren_a, raddr_a, ren_b, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );
endinterface

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - register file, 1 sync write + 2 registered read ports; RF_BYPASS_EN enables write-first forwarding
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_multiport_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              w_ok;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  // A write lands only in range and never into a hardwired zero register
  always_comb begin
    w_ok = bus.wen && ({1'b0, bus.waddr} < DEPTH_L)
           && !((ZERO_REG != 0) && (bus.waddr == '0));
  end

  // Storage update; reset clears every register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (w_ok) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Port A read data select: zero reg, out of range, optional forward, stored value
  always_comb begin
    sel_a = '0;
    if ((ZERO_REG != 0) && (bus.raddr_a == '0)) begin
      sel_a = '0;
    end else if ({1'b0, bus.raddr_a} >= DEPTH_L) begin
      sel_a = '0;
`ifdef RF_BYPASS_EN
    end else if (w_ok && (bus.waddr == bus.raddr_a)) begin
      sel_a = bus.wdata;
`endif
    end else begin
      sel_a = regs[bus.raddr_a];
    end
  end

  // Port B read data select, same priority as port A
  always_comb begin
    sel_b = '0;
    if ((ZERO_REG != 0) && (bus.raddr_b == '0)) begin
      sel_b = '0;
    end else if ({1'b0, bus.raddr_b} >= DEPTH_L) begin
      sel_b = '0;
`ifdef RF_BYPASS_EN
    end else if (w_ok && (bus.waddr == bus.raddr_b)) begin
      sel_b = bus.wdata;
`endif
    end else begin
      sel_b = regs[bus.raddr_b];
    end
  end

  // Port A output register; data holds when not reading, valid follows ren_a
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata_a  <= '0;
      bus.rvalid_a <= 1'b0;
    end else begin
      bus.rvalid_a <= bus.ren_a;
      if (bus.ren_a) bus.rdata_a <= sel_a;
    end
  end

  // Port B output register; data holds when not reading, valid follows ren_b
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata_b  <= '0;
      bus.rvalid_b <= 1'b0;
    end else begin
      bus.rvalid_b <= bus.ren_b;
      if (bus.ren_b) bus.rdata_b <= sel_b;
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - directed self-checking bench for rf_multiport
module tb_rf_multiport;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

`ifdef RF_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'h22;
`else
  localparam logic [31:0] COLL_EXP = 32'h11;
`endif

  rf_multiport_if #(.DATA_W(32), .ADDR_W(4)) bus16 ();
  rf_multiport_if #(.DATA_W(32), .ADDR_W(4)) bus12 ();
  rf_multiport_if #(.DATA_W(32), .ADDR_W(4)) busz ();

  rf_multiport #(.DATA_W(32), .DEPTH(16), .ZERO_REG(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );
  rf_multiport #(.DATA_W(32), .DEPTH(12), .ZERO_REG(1)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .bus(bus12)
  );
  rf_multiport #(.DATA_W(32), .DEPTH(16), .ZERO_REG(0)) u_dutz (
    .clk(clk), .rst_n(rst_n), .bus(busz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus16.wen = 0; bus16.waddr = '0; bus16.wdata = '0;
    bus16.ren_a = 0; bus16.raddr_a = '0; bus16.ren_b = 0; bus16.raddr_b = '0;
    bus12.wen = 0; bus12.waddr = '0; bus12.wdata = '0;
    bus12.ren_a = 0; bus12.raddr_a = '0; bus12.ren_b = 0; bus12.raddr_b = '0;
    busz.wen = 0; busz.waddr = '0; busz.wdata = '0;
    busz.ren_a = 0; busz.raddr_a = '0; busz.ren_b = 0; busz.raddr_b = '0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata_a", bus16.rdata_a, 32'h0);
    chk("rst_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h0);
    chk("rst_rvalid_b", {31'b0, bus16.rvalid_b}, 32'h0);

    // Reset then read regs 5 and 15
    rst_n = 1'b1;
    bus16.ren_a = 1; bus16.raddr_a = 4'd5;
    bus16.ren_b = 1; bus16.raddr_b = 4'd15;
    #1;
    chk("pre_read_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h0);
    tick();
    idle_all();
    chk("rd5_rdata_a", bus16.rdata_a, 32'h0);
    chk("rd15_rdata_b", bus16.rdata_b, 32'h0);
    chk("rd5_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h1);
    chk("rd15_rvalid_b", {31'b0, bus16.rvalid_b}, 32'h1);

    // Basic write then read
    bus16.wen = 1; bus16.waddr = 4'd3; bus16.wdata = 32'hDEADBEEF;
    tick();
    idle_all();
    bus16.ren_a = 1; bus16.raddr_a = 4'd3;
    tick();
    idle_all();
    chk("wr3_rdata_a", bus16.rdata_a, 32'hDEADBEEF);
    chk("wr3_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h1);
    tick();
    chk("idle_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h0);
    chk("idle_hold_rdata_a", bus16.rdata_a, 32'hDEADBEEF);

    // Back-to-back reads keep rvalid high
    bus16.ren_a = 1; bus16.raddr_a = 4'd3;
    tick();
    chk("b2b1_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h1);
    bus16.raddr_a = 4'd5;
    tick();
    idle_all();
    chk("b2b2_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h1);
    chk("b2b2_rdata_a", bus16.rdata_a, 32'h0);

    // Zero register, ZERO_REG=1 vs ZERO_REG=0
    bus16.wen = 1; bus16.waddr = 4'd0; bus16.wdata = 32'h12345678;
    busz.wen = 1; busz.waddr = 4'd0; busz.wdata = 32'h12345678;
    tick();
    idle_all();
    bus16.ren_a = 1; bus16.ren_b = 1;
    busz.ren_a = 1; busz.ren_b = 1;
    tick();
    idle_all();
    chk("zr1_rdata_a", bus16.rdata_a, 32'h0);
    chk("zr1_rdata_b", bus16.rdata_b, 32'h0);
    chk("zr0_rdata_a", busz.rdata_a, 32'h12345678);
    chk("zr0_rdata_b", busz.rdata_b, 32'h12345678);

    // Same-cycle read/write collision on reg 7
    bus16.wen = 1; bus16.waddr = 4'd7; bus16.wdata = 32'h11;
    tick();
    bus16.wdata = 32'h22;
    bus16.ren_a = 1; bus16.raddr_a = 4'd7;
    tick();
    idle_all();
    chk("coll_rdata_a", bus16.rdata_a, COLL_EXP);
    bus16.ren_b = 1; bus16.raddr_b = 4'd7;
    tick();
    idle_all();
    chk("coll_next_rdata_b", bus16.rdata_b, 32'h22);

    // Dropped write to reg 0 is never forwarded
    bus16.wen = 1; bus16.waddr = 4'd0; bus16.wdata = 32'h99;
    bus16.ren_b = 1; bus16.raddr_b = 4'd0;
    tick();
    idle_all();
    chk("zr_nofwd_rdata_b", bus16.rdata_b, 32'h0);

    // Out of range, DEPTH=12
    bus12.wen = 1; bus12.waddr = 4'd1; bus12.wdata = 32'h0101;
    tick();
    bus12.waddr = 4'd13; bus12.wdata = 32'hAAAA;
    bus12.ren_a = 1; bus12.raddr_a = 4'd13;
    tick();
    idle_all();
    chk("oor_same_rdata_a", bus12.rdata_a, 32'h0);
    bus12.ren_a = 1; bus12.raddr_a = 4'd13;
    bus12.ren_b = 1; bus12.raddr_b = 4'd1;
    tick();
    idle_all();
    chk("oor13_rdata_a", bus12.rdata_a, 32'h0);
    chk("oor_reg1_rdata_b", bus12.rdata_b, 32'h0101);
    for (int i = 0; i < 16; i++) begin
      bus12.ren_a = 1; bus12.raddr_a = 4'(i);
      tick();
      chk($sformatf("oor_scan_%0d", i), bus12.rdata_a, (i == 1) ? 32'h0101 : 32'h0);
    end
    idle_all();

    // Reset mid-operation
    bus16.wen = 1; bus16.waddr = 4'd4; bus16.wdata = 32'h55;
    bus16.ren_a = 1; bus16.raddr_a = 4'd3;
    tick();
    chk("pre_rst_rdata_a", bus16.rdata_a, 32'hDEADBEEF);
    chk("pre_rst_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h1);
    bus16.wen = 1; bus16.waddr = 4'd4; bus16.wdata = 32'h66;
    bus16.ren_a = 1; bus16.raddr_a = 4'd4;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata_a", bus16.rdata_a, 32'h0);
    chk("mid_rst_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h0);
    chk("mid_rst_rdata_b", bus16.rdata_b, 32'h0);
    tick();
    idle_all();
    rst_n = 1'b1;
    bus16.ren_a = 1; bus16.raddr_a = 4'd4;
    bus16.ren_b = 1; bus16.raddr_b = 4'd7;
    tick();
    idle_all();
    chk("post_rst_reg4", bus16.rdata_a, 32'h0);
    chk("post_rst_reg7", bus16.rdata_b, 32'h0);
    chk("post_rst_rvalid_a", {31'b0, bus16.rvalid_a}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised register file; successor to the 4x32 single-port combinational RF.
- One synchronous write port and two independent registered read ports, A and B, each with a read-enable/valid handshake.
- Register 0 is optionally hardwired to zero; out-of-range addresses are handled safely.
- Sits between decode/execute and writeback in the core datapath.

Parameters:
- DATA_W, 32, width of each register in bits
- DEPTH, 16, number of registers; need not be a power of two, minimum 2
- ADDR_W, $clog2(DEPTH), address width; derived, do not override
- ZERO_REG, 1, when 1, register 0 reads as 0 and writes to it are discarded

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- wen  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- ren_a  input  1  read enable, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  DATA_W  registered read data, port A
- rvalid_a  output  1  one-cycle pulse: rdata_a updated this cycle
- ren_b  input  1  read enable, port B
- raddr_b  input  ADDR_W  read address, port B
- rdata_b  output  DATA_W  registered read data, port B
- rvalid_b  output  1  one-cycle pulse: rdata_b updated this cycle

Behaviour:
- Reset:
  - rst_n low asynchronously clears all DEPTH registers to 0.
  - rdata_a, rdata_b, rvalid_a and rvalid_b are all 0.
  - Reset asserted mid-operation discards any write or read in flight; no partial update.
  - First write is accepted on the first rising edge with rst_n high.
- Write:
  - On a rising edge with wen=1 and waddr<DEPTH, reg[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0, the write is dropped.
  - If waddr>=DEPTH, the write is dropped and no register changes.
- Read latency is 1 cycle:
  - With ren_x=1 at edge N, rdata_x and rvalid_x=1 appear after edge N.
  - rvalid_x is a single-cycle pulse that follows ren_x delayed one cycle; back-to-back reads give a continuous rvalid_x.
  - With ren_x=0, rdata_x holds its previous value and rvalid_x=0.
- Read data selection, in priority order:
  - ZERO_REG=1 and raddr_x=0: data is 0.
  - raddr_x>=DEPTH: data is 0.
  - Same-edge write with wen=1 and waddr==raddr_x (write accepted per the write rules): governed by the optional feature below.
  - Otherwise: reg[raddr_x] as held before the edge.
- Both ports may read the same address in the same cycle and return identical data.
- No backpressure: the read ports accept every cycle; the write port accepts every cycle.
- No combinational path from any input to any output.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read at edge N whose address matches an accepted write at edge N returns wdata (write-first forwarding). A dropped write (register 0 with ZERO_REG=1, or out of range) is never forwarded.
- Undefined: such a read returns the old register contents (read-first). The new value is visible to reads issued from edge N+1.
- Write behaviour is identical either way.

Test Plan:
- Reset then read, DEPTH=16: hold rst_n=0 for 3 cycles, release, then ren_a=1 raddr_a=5 and ren_b=1 raddr_b=15 -> next cycle rdata_a=0, rdata_b=0, rvalid_a=rvalid_b=1; before any read both rvalid are 0.
- Basic write/read: write 0xDEADBEEF to reg 3, next cycle read 3 on port A -> one cycle later rdata_a=0xDEADBEEF, rvalid_a=1; the following idle cycle gives rvalid_a=0 and rdata_a still 0xDEADBEEF.
- Zero register, ZERO_REG=1: write 0x12345678 to reg 0, then read 0 on both ports -> rdata_a=rdata_b=0. Repeat with ZERO_REG=0 -> both read 0x12345678.
- Same-cycle read/write collision: reg 7 holds 0x11; in one cycle write 0x22 to 7 and read 7 on A -> rdata_a=0x22 with RF_BYPASS_EN, 0x11 without; a read of 7 on the next cycle gives 0x22 in both builds.
- Out of range, DEPTH=12: write 0xAAAA to addr 13, then read 13 and 1 -> rdata for addr 13 is 0; reg 1 is unchanged; no register holds 0xAAAA.
- Reset mid-operation: write reg 4=0x55, then assert rst_n low asynchronously mid-cycle while wen=1 waddr=4 wdata=0x66 and ren_a=1 -> outputs go to 0 immediately; after release, reading 4 returns 0.
